// File: rtl/button_enable_gen_pkg.sv
// Shared types and helpers for the push-button enable generator.
// Holds the FSM state type, parameter floors and the timer width helper.
package button_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESS_DB   = 3'd1,
    HELD       = 3'd2,
    REPEAT     = 3'd3,
    RELEASE_DB = 3'd4
  } state_t;

  localparam int MIN_SYNC_STAGES = 2;
  localparam int MIN_CYCLES      = 2;

  // Smallest w such that 2**w >= v.
  function automatic int clog2_int(input int v);
    int w;
    w = 0;
    while ((1 << w) < v) begin
      w = w + 1;
    end
    return w;
  endfunction

  function automatic int tmr_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return clog2_int(m) + 1;
  endfunction

endpackage

// File: rtl/button_enable_gen_if.sv
// Button-side signal bundle: raw button and repeat control in, pulse and status out.
interface button_enable_gen_if;
  logic btn_raw;
  logic repeat_en;
  logic enable_pulse;
  logic btn_level;
  logic repeating;

  modport slave (
    input  btn_raw,
    input  repeat_en,
    output enable_pulse,
    output btn_level,
    output repeating
  );

  modport master (
    output btn_raw,
    output repeat_en,
    input  enable_pulse,
    input  btn_level,
    input  repeating
  );
endinterface

// File: rtl/button_enable_gen_bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous bit; q lags d by STAGES clocks.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign sync_d[gi] = d;
      end else begin : g_next
        assign sync_d[gi] = sync_q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/button_enable_gen.sv
// Push-button to counter-enable converter: synchronise, debounce, and emit one
// pulse per press plus optional auto-repeat pulses while the button is held.
module button_enable_gen
  import button_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16,
  parameter int TMR_W           = tmr_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)
) (
  input  logic                clk,
  input  logic                reset,
  button_enable_gen_if.slave  bus
);

  localparam logic [TMR_W-1:0] DB_LAST  = TMR_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] RD_LAST  = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] RP_LAST  = TMR_W'(REPEAT_PERIOD - 1);

  logic             btn_sync;
  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             pulse_q, pulse_d;
  logic             level_q, level_d;
  logic             rep_q, rep_d;

  bit_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.btn_raw),
    .q     (btn_sync)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (btn_sync) state_d = PRESS_DB;
      end
      PRESS_DB: begin
        if (!btn_sync) begin
          state_d = IDLE;
        end else if (timer_q == DB_LAST) begin
          state_d = HELD;
          pulse_d = 1'b1;
        end
      end
      HELD: begin
        if (!btn_sync) begin
          state_d = RELEASE_DB;
        end else if (timer_q == RD_LAST) begin
          if (bus.repeat_en) begin
            state_d = REPEAT;
            pulse_d = 1'b1;
          end else begin
            // Park at the terminal count until repeat is enabled or released.
            timer_d = timer_q;
          end
        end
      end
      REPEAT: begin
        // Release beats repeat_en drop, which beats a terminal-count pulse.
        if (!btn_sync) begin
          state_d = RELEASE_DB;
        end else if (!bus.repeat_en) begin
          state_d = HELD;
        end else if (timer_q == RP_LAST) begin
          pulse_d = 1'b1;
          timer_d = '0;
        end
      end
      RELEASE_DB: begin
        if (btn_sync) begin
          state_d = HELD;
        end else if (timer_q == DB_LAST) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (state_d != state_q) timer_d = '0;
    level_d = (state_d == HELD) || (state_d == REPEAT) || (state_d == RELEASE_DB);
    rep_d   = (state_d == REPEAT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
      rep_q   <= rep_d;
    end
  end

  assign bus.enable_pulse = pulse_q;
  assign bus.btn_level    = level_q;
  assign bus.repeating    = rep_q;

endmodule

// File: tb/tb_button_enable_gen.sv
// Directed bench for button_enable_gen: expected pulse cycles go into a queue,
// a negedge monitor pops and compares each pulse the DUT emits.
module tb_button_enable_gen;

  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int RD   = 10;
  localparam int RP   = 3;
  localparam int LAT  = SYNC + DB;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  button_enable_gen_if bus_if ();

  button_enable_gen #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   mon_exp;
  int   chain_count = 0;
  logic prev_pulse = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream counter fed by enable_pulse.
  always @(posedge clk) begin
    if (bus_if.enable_pulse) chain_count <= chain_count + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp = n_cmp + 1;
    if (act !== req) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_pulse <= 1'b0;
    end else begin
      if (bus_if.enable_pulse) begin
        if (prev_pulse) begin
          n_cmp = n_cmp + 1;
          n_bad = n_bad + 1;
          $display("FAIL pulse_gap: pulse high on two consecutive cycles, at cycle %0d", cyc);
        end
        if (exp_q.size() == 0) begin
          n_cmp = n_cmp + 1;
          n_bad = n_bad + 1;
          $display("FAIL unexpected_pulse: pulse at cycle %0d, none expected", cyc);
        end else begin
          mon_exp = exp_q.pop_front();
          check("pulse_cycle", cyc, mon_exp);
          check("level_at_pulse", bus_if.btn_level, 1);
        end
      end
      prev_pulse <= bus_if.enable_pulse;
    end
  end

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int s;
    int start_count;
    bus_if.btn_raw   = 1'b0;
    bus_if.repeat_en = 1'b0;
    reset            = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_pulse", bus_if.enable_pulse, 0);
    check("reset_level", bus_if.btn_level, 0);
    check("reset_repeating", bus_if.repeating, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Clean press, 8 samples high, repeat disabled.
    bus_if.btn_raw = 1'b1;
    base = cyc + 1;
    exp_q.push_back(base + LAT);
    wait_to(base + LAT - 1);
    check("clean_level_before", bus_if.btn_level, 0);
    wait_to(base + LAT);
    check("clean_level_rise", bus_if.btn_level, 1);
    wait_to(base + 7);
    bus_if.btn_raw = 1'b0;
    s = base + 8;
    wait_to(s + SYNC + DB - 1);
    check("clean_level_hold", bus_if.btn_level, 1);
    wait_to(s + SYNC + DB);
    check("clean_level_fall", bus_if.btn_level, 0);
    wait_to(cyc + 4);

    // Press-side bounce: single-cycle highs never survive debounce.
    for (int i = 0; i < 10; i++) begin
      bus_if.btn_raw = (i % 2 == 0);
      @(negedge clk);
      check("bounce_level", bus_if.btn_level, 0);
    end
    bus_if.btn_raw = 1'b0;
    wait_to(cyc + 10);
    check("bounce_level_after", bus_if.btn_level, 0);

    // Long hold parks HELD at terminal count, then release with 2-cycle bounces.
    bus_if.btn_raw = 1'b1;
    base = cyc + 1;
    exp_q.push_back(base + LAT);
    wait_to(base + 19);
    for (int i = 0; i < 8; i++) begin
      bus_if.btn_raw = (i % 4 >= 2);
      @(negedge clk);
    end
    check("relbounce_level", bus_if.btn_level, 1);
    bus_if.btn_raw = 1'b0;
    s = cyc + 1;
    wait_to(s + SYNC + DB - 1);
    check("relbounce_level_hold", bus_if.btn_level, 1);
    wait_to(s + SYNC + DB);
    check("relbounce_level_fall", bus_if.btn_level, 0);
    wait_to(cyc + 4);

    // Auto-repeat; release lands on the same cycle as a repeat terminal count.
    bus_if.repeat_en = 1'b1;
    bus_if.btn_raw   = 1'b1;
    base = cyc + 1;
    exp_q.push_back(base + 6);
    exp_q.push_back(base + 16);
    exp_q.push_back(base + 19);
    exp_q.push_back(base + 22);
    exp_q.push_back(base + 25);
    exp_q.push_back(base + 28);
    wait_to(base + 15);
    check("repeat_before", bus_if.repeating, 0);
    wait_to(base + 16);
    check("repeat_rise", bus_if.repeating, 1);
    wait_to(base + 28);
    bus_if.btn_raw = 1'b0;
    s = base + 29;
    wait_to(base + 30);
    check("repeat_still", bus_if.repeating, 1);
    wait_to(base + 31);
    check("repeat_release_wins", bus_if.repeating, 0);
    bus_if.repeat_en = 1'b0;
    wait_to(s + SYNC + DB);
    check("repeat_level_fall", bus_if.btn_level, 0);
    wait_to(cyc + 4);

    // repeat_en drops exactly on a REPEAT terminal count: HELD wins, no pulse.
    bus_if.repeat_en = 1'b1;
    bus_if.btn_raw   = 1'b1;
    base = cyc + 1;
    exp_q.push_back(base + 6);
    exp_q.push_back(base + 16);
    exp_q.push_back(base + 19);
    wait_to(base + 21);
    bus_if.repeat_en = 1'b0;
    wait_to(base + 22);
    check("repdrop_repeating", bus_if.repeating, 0);
    check("repdrop_level", bus_if.btn_level, 1);
    wait_to(base + 35);
    bus_if.btn_raw = 1'b0;
    s = base + 36;
    wait_to(s + SYNC + DB);
    check("repdrop_level_fall", bus_if.btn_level, 0);
    wait_to(cyc + 4);

    // Asynchronous reset right after the press pulse, button kept pressed.
    bus_if.btn_raw = 1'b1;
    base = cyc + 1;
    exp_q.push_back(base + LAT);
    wait_to(base + LAT);
    #1 reset = 1'b1;
    #1;
    check("async_reset_pulse", bus_if.enable_pulse, 0);
    check("async_reset_level", bus_if.btn_level, 0);
    check("async_reset_repeating", bus_if.repeating, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    base = cyc + 1;
    exp_q.push_back(base + LAT);
    wait_to(base + LAT - 1);
    check("post_reset_level_before", bus_if.btn_level, 0);
    wait_to(base + LAT);
    check("post_reset_level_rise", bus_if.btn_level, 1);
    bus_if.btn_raw = 1'b0;
    wait_to(cyc + 12);

    // Five clean presses into the downstream counter.
    start_count = chain_count;
    for (int k = 0; k < 5; k++) begin
      bus_if.btn_raw = 1'b1;
      base = cyc + 1;
      exp_q.push_back(base + LAT);
      wait_to(base + 7);
      bus_if.btn_raw = 1'b0;
      wait_to(base + 19);
    end
    check("chain_count", chain_count - start_count, 5);

    wait_to(cyc + 5);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/button_enable_gen.md
Name: button_enable_gen

Overview:
- Upstream stage of the N-bit up-counter.
- Converts a raw, bouncing push-button input into clean single-cycle enable pulses that drive the counter's enable input.
- Synchronises the input, then debounces it.
- Emits one pulse per press, plus optional auto-repeat pulses while the button is held.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on btn_raw (minimum 2).
- DEBOUNCE_CYCLES, 16, consecutive stable samples required to accept a press or a release (minimum 2).
- REPEAT_DELAY, 64, cycles held in HELD before the first auto-repeat pulse (minimum 2).
- REPEAT_PERIOD, 16, cycles between auto-repeat pulses in REPEAT (minimum 2).
- TMR_W, clog2(max of the three cycle parameters)+1, width of the shared timer.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- btn_raw  in  1  asynchronous raw button level; 1 = pressed.
- repeat_en  in  1  enables auto-repeat; sampled every cycle.
- enable_pulse  out  1  registered, one-cycle-wide pulse to the counter's enable.
- btn_level  out  1  registered debounced button level.
- repeating  out  1  high while the FSM is in REPEAT.

Behaviour:
- Reset: asynchronous and active-high. While reset is high:
  - FSM = IDLE, timer = 0, synchroniser flops = 0;
  - enable_pulse = 0, btn_level = 0, repeating = 0.
- Reset mid-operation aborts any state immediately; no pulse is emitted on reset release.
- btn_sync: output of the SYNC_STAGES-deep synchroniser. The FSM uses only btn_sync.
- Timer: single TMR_W-bit counter. It clears on every state change and increments otherwise. It never wraps, because every state exits or clears at its terminal value.
- IDLE:
  - btn_level = 0.
  - btn_sync = 1 -> PRESS_DB.
- PRESS_DB:
  - btn_sync = 0 -> IDLE, no pulse (glitch rejected).
  - timer == DEBOUNCE_CYCLES-1 with btn_sync = 1 -> HELD; enable_pulse = 1 for that one cycle; btn_level = 1.
- HELD:
  - btn_sync = 0 -> RELEASE_DB.
  - timer == REPEAT_DELAY-1 and repeat_en = 1 -> REPEAT; pulse.
  - timer == REPEAT_DELAY-1 and repeat_en = 0 -> timer holds at the terminal value, no pulse.
- REPEAT:
  - repeating = 1.
  - btn_sync = 0 -> RELEASE_DB.
  - repeat_en = 0 -> HELD with timer = 0.
  - timer == REPEAT_PERIOD-1 -> pulse; timer = 0; stay in REPEAT.
- RELEASE_DB:
  - btn_level stays 1.
  - btn_sync = 1 -> HELD with timer = 0, no pulse (release bounce does not count as a press).
  - timer == DEBOUNCE_CYCLES-1 with btn_sync = 0 -> IDLE; btn_level = 0.
- Latency:
  - From the first clock edge that samples btn_raw = 1 to enable_pulse high = SYNC_STAGES + DEBOUNCE_CYCLES cycles.
  - btn_level rises in the same cycle as that first pulse.
- Simultaneous events:
  - btn_sync falling on the same cycle a repeat terminal count is reached: the release wins, no pulse.
  - repeat_en falling on a REPEAT terminal count: HELD wins, no pulse.
- Pulse rules:
  - enable_pulse is never high on two consecutive cycles.
  - enable_pulse is driven only by the registered FSM transition, with no combinational path from btn_raw.

Decomposition:
- Shared package button_pkg holds:
  - state typedef: IDLE, PRESS_DB, HELD, REPEAT, RELEASE_DB;
  - a clog2-style width function for TMR_W;
  - the parameter minimum-value constants.
- One natural sub-module: bit_synchronizer.
  - Parameter STAGES; ports clk, reset, d, q.
  - Reusable across the codebase for any asynchronous input.

Test Plan (bench parameters SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3):
- Reset check: assert reset mid-HELD with btn_raw = 1 -> outputs 0 on the same edge; after release, btn_raw held at 1 -> first pulse 6 cycles later.
- Clean press: btn_raw 0->1 held 8 cycles, repeat_en = 0 -> exactly one enable_pulse at cycle 6; btn_level = 1 from cycle 6.
- Bounce rejection, press side: btn_raw toggles 1,0,1,0 per cycle for 10 cycles, then 0 -> zero pulses; btn_level stays 0.
- Bounce rejection, release side: held press, then a release with 2-cycle bounces, then a stable release -> no extra pulse; btn_level falls 4 cycles after the stable-low synchronised sample.
- Auto-repeat: repeat_en = 1, btn_raw held 30 cycles -> pulses at cycles 6, 16, 19, 22, 25, 28; repeating high from cycle 16.
- Chain check: drive the counter's enable from enable_pulse; 5 clean presses -> count = 5 with no double increments.
